// File: rtl/econet_hdlc_rx.sv
// Econet (HDLC) bit-level receive deframer.
//
// Samples the serial line and hunts for an opening flag. Inside a frame it removes stuffed
// zeros and detects aborts. It assembles LSB-first octets and runs a reflected CRC-16 (X.25)
// over the frame. Octet and frame events go out as single-cycle strobes to the buffered
// receive stage. Everything runs on the rising edge of econet_clk.
//
// Ports
//   econet_clk      in   line clock
//   valid_rst       in   asynchronous active-high reset
//   rx              in   serial line data
//   inhibit         in   high = ignore the line (own transmission in progress)
//   rx_byte         out  last assembled octet, held until the next rx_byte_ready
//   rx_fcs          out  CRC register at frame close (16'hF0B8 = good), 0 on a bad end
//   rx_byte_ready   out  1-cycle strobe, rx_byte valid
//   rx_frame_start  out  1-cycle strobe ahead of the first rx_byte_ready of a frame
//   rx_frame_end    out  1-cycle strobe, frame closed or aborted
//   receiving       out  high from the rx_frame_start cycle through the rx_frame_end cycle
module econet_hdlc_rx #(
  parameter int unsigned MAX_BYTES = 2048,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF,
  parameter logic [15:0] CRC_POLY  = 16'h8408
) (
  input  logic        econet_clk,
  input  logic        valid_rst,
  input  logic        rx,
  input  logic        inhibit,
  output logic [7:0]  rx_byte,
  output logic [15:0] rx_fcs,
  output logic        rx_byte_ready,
  output logic        rx_frame_start,
  output logic        rx_frame_end,
  output logic        receiving
);

  localparam int unsigned    CntW      = $clog2(MAX_BYTES + 2);
  localparam logic [CntW-1:0] ByteLimit = CntW'(MAX_BYTES + 1);

  typedef enum logic [0:0] {StHunt, StData} state_e;

  state_e          state_q, state_d;
  logic [7:0]      hist_q, hist_d;
  logic [2:0]      ones_q, ones_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [CntW-1:0] bytecnt_q, bytecnt_d;
  logic [15:0]     crc_q, crc_d;
  logic [15:0]     snap_q, snap_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            started_q, started_d;
  logic [7:0]      byte_hold_q, byte_hold_d;
  logic            byte_pend_q, byte_pend_d;
  logic            end_pend_q, end_pend_d;
  logic [15:0]     fcs_pend_q, fcs_pend_d;
  logic            frame_start_q, frame_start_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic [15:0]     rx_fcs_q, rx_fcs_d;
  logic            byte_ready_q, byte_ready_d;
  logic            frame_end_q, frame_end_d;
  logic            receiving_q, receiving_d;

  logic [2:0]  ones_nxt;
  logic [15:0] crc_bit;
  logic [CntW-1:0] bytecnt_inc;
  logic        abort;

  assign ones_nxt    = rx ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
  assign crc_bit     = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ rx) ? CRC_POLY : 16'h0000);
  assign bytecnt_inc = bytecnt_q + CntW'(1);

  always_comb begin
    state_d       = state_q;
    hist_d        = hist_q;
    ones_d        = ones_nxt;
    bitcnt_d      = bitcnt_q;
    bytecnt_d     = bytecnt_q;
    crc_d         = crc_q;
    snap_d        = snap_q;
    shreg_d       = shreg_q;
    started_d     = started_q;
    byte_hold_d   = byte_hold_q;
    byte_pend_d   = 1'b0;
    end_pend_d    = 1'b0;
    fcs_pend_d    = fcs_pend_q;
    frame_start_d = 1'b0;
    abort         = 1'b0;

    if (inhibit) begin
      abort  = 1'b1;
      ones_d = 3'd0;
    end else begin
      case (state_q)
        StHunt: begin
          hist_d = {hist_q[6:0], rx};
          if ({hist_q[6:0], rx} == 8'h7E) begin
            state_d   = StData;
            crc_d     = CRC_INIT;
            bitcnt_d  = 3'd0;
            bytecnt_d = '0;
            started_d = 1'b0;
          end
        end
        StData: begin
          if (ones_q == 3'd5 && !rx) begin
            // Stuffed zero: dropped without touching the octet or CRC.
          end else if (ones_q >= 3'd6) begin
            if (rx) begin
              abort = 1'b1;
            end else begin
              // Flag. A clean close leaves exactly the flag's 0 + five 1s in the octet.
              if (started_q) begin
                end_pend_d = 1'b1;
                fcs_pend_d = (bitcnt_q == 3'd6 && bytecnt_q != '0) ? snap_q : 16'h0000;
              end
              started_d = 1'b0;
              crc_d     = CRC_INIT;
              bitcnt_d  = 3'd0;
              bytecnt_d = '0;
            end
          end else if (ones_q == 3'd5) begin
            // Sixth one: not data; the next bit decides between flag and abort.
          end else begin
            shreg_d  = {rx, shreg_q[7:1]};
            crc_d    = crc_bit;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              snap_d    = crc_bit;
              bytecnt_d = bytecnt_inc;
              if (bytecnt_inc == ByteLimit) begin
                // Oversize frame: the excess octet is not delivered.
                abort = 1'b1;
              end else begin
                byte_hold_d = {rx, shreg_q[7:1]};
                byte_pend_d = 1'b1;
                if (!started_q) begin
                  frame_start_d = 1'b1;
                  started_d     = 1'b1;
                end
              end
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (abort) begin
      state_d   = StHunt;
      hist_d    = 8'h00;
      started_d = 1'b0;
      if (started_q) begin
        end_pend_d = 1'b1;
        fcs_pend_d = 16'h0000;
      end
    end

    // Output stage: bytes and frame ends are presented one cycle after they are decided.
    byte_ready_d = byte_pend_q;
    rx_byte_d    = byte_pend_q ? byte_hold_q : rx_byte_q;
    frame_end_d  = end_pend_q;
    rx_fcs_d     = end_pend_q ? fcs_pend_q : rx_fcs_q;

    if (frame_start_d) begin
      receiving_d = 1'b1;
    end else if (frame_end_q) begin
      receiving_d = 1'b0;
    end else begin
      receiving_d = receiving_q;
    end
  end

  always_ff @(posedge econet_clk or posedge valid_rst) begin
    if (valid_rst) begin
      state_q       <= StHunt;
      hist_q        <= 8'h00;
      ones_q        <= 3'd0;
      bitcnt_q      <= 3'd0;
      bytecnt_q     <= '0;
      crc_q         <= CRC_INIT;
      snap_q        <= 16'h0000;
      shreg_q       <= 8'h00;
      started_q     <= 1'b0;
      byte_hold_q   <= 8'h00;
      byte_pend_q   <= 1'b0;
      end_pend_q    <= 1'b0;
      fcs_pend_q    <= 16'h0000;
      frame_start_q <= 1'b0;
      rx_byte_q     <= 8'h00;
      rx_fcs_q      <= 16'h0000;
      byte_ready_q  <= 1'b0;
      frame_end_q   <= 1'b0;
      receiving_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      ones_q        <= ones_d;
      bitcnt_q      <= bitcnt_d;
      bytecnt_q     <= bytecnt_d;
      crc_q         <= crc_d;
      snap_q        <= snap_d;
      shreg_q       <= shreg_d;
      started_q     <= started_d;
      byte_hold_q   <= byte_hold_d;
      byte_pend_q   <= byte_pend_d;
      end_pend_q    <= end_pend_d;
      fcs_pend_q    <= fcs_pend_d;
      frame_start_q <= frame_start_d;
      rx_byte_q     <= rx_byte_d;
      rx_fcs_q      <= rx_fcs_d;
      byte_ready_q  <= byte_ready_d;
      frame_end_q   <= frame_end_d;
      receiving_q   <= receiving_d;
    end
  end

  assign rx_byte        = rx_byte_q;
  assign rx_fcs         = rx_fcs_q;
  assign rx_byte_ready  = byte_ready_q;
  assign rx_frame_start = frame_start_q;
  assign rx_frame_end   = frame_end_q;
  assign receiving      = receiving_q;

endmodule

// File: tb/tb_econet_hdlc_rx.sv
// Bench for econet_hdlc_rx: table of frames plus hand-written latency, inhibit, reset and
// oversize-frame sequences.
module tb_econet_hdlc_rx;

  logic        econet_clk = 1'b0;
  logic        valid_rst;
  logic        rx;
  logic        inhibit;
  logic [7:0]  rx_byte;
  logic [15:0] rx_fcs;
  logic        rx_byte_ready;
  logic        rx_frame_start;
  logic        rx_frame_end;
  logic        receiving;

  always #5 econet_clk = ~econet_clk;

  econet_hdlc_rx dut (
    .econet_clk     (econet_clk),
    .valid_rst      (valid_rst),
    .rx             (rx),
    .inhibit        (inhibit),
    .rx_byte        (rx_byte),
    .rx_fcs         (rx_fcs),
    .rx_byte_ready  (rx_byte_ready),
    .rx_frame_start (rx_frame_start),
    .rx_frame_end   (rx_frame_end),
    .receiving      (receiving)
  );

  typedef struct {
    string       name;
    int          npay;
    logic [47:0] pay;        // byte i at [8*i +: 8], sent first to last
    int          fcs_mode;   // 0 none, 1 good FCS, 2 corrupted FCS
    int          tail;       // 0 closing flag, 1 seven ones (abort), 2 four stray bits + flag
    int          exp_starts;
    int          exp_ends;
    int          fcs_kind;   // 0 expect exp_fcs, 1 expect CRC over everything sent
    logic [15:0] exp_fcs;
    logic        has_extra;  // an extra octet formed by stray bits + flag
    logic [7:0]  extra;
  } vec_t;

  vec_t vq[$];

  int          checks = 0;
  int          errors = 0;
  int          n_start, n_end, n_byte, viol;
  logic [7:0]  got [16];
  logic [15:0] last_fcs;
  logic        recv_m, end_prev;
  int          tx_ones;

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) c = {1'b0, c[15:1]} ^ ((c[0] ^ d[i]) ? 16'h8408 : 16'h0000);
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_acc();
    n_start = 0;
    n_end   = 0;
    n_byte  = 0;
    viol    = 0;
    last_fcs = 16'h0000;
  endtask

  // Per-cycle observation: counts strobes and tracks the expected receiving level.
  task automatic sample();
    int ns;
    ns = int'(rx_byte_ready) + int'(rx_frame_start) + int'(rx_frame_end);
    if (ns > 1) viol++;
    if (rx_frame_start) begin
      n_start++;
      recv_m = 1'b1;
    end else if (end_prev) begin
      recv_m = 1'b0;
    end
    if (receiving !== recv_m) viol++;
    if (rx_byte_ready) begin
      if (!recv_m) viol++;
      if (n_byte < 16) got[n_byte] = rx_byte;
      n_byte++;
    end
    if (rx_frame_end) begin
      if (!recv_m) viol++;
      n_end++;
      last_fcs = rx_fcs;
    end
    end_prev = rx_frame_end;
  endtask

  task automatic tick(input logic b);
    rx = b;
    @(posedge econet_clk);
    #1;
    sample();
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) tick(f[i]);
    tx_ones = 0;
  endtask

  task automatic send_stuffed_bit(input logic b);
    tick(b);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 5) begin
      tick(1'b0);
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_stuffed_bit(b[i]);
  endtask

  task automatic add_vec(input string nm, input int np, input logic [47:0] pay, input int fm,
                         input int tl, input int es, input int ee, input int fk,
                         input logic [15:0] ef, input logic hx, input logic [7:0] ex);
    vec_t v;
    v.name = nm; v.npay = np; v.pay = pay; v.fcs_mode = fm; v.tail = tl;
    v.exp_starts = es; v.exp_ends = ee; v.fcs_kind = fk; v.exp_fcs = ef;
    v.has_extra = hx; v.extra = ex;
    vq.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  exp_b[$];
    logic [15:0] c;
    logic [15:0] fcs;
    logic [7:0]  b;
    c = 16'hFFFF;
    clr_acc();
    send_flag();
    send_flag();
    for (int i = 0; i < v.npay; i++) begin
      b = v.pay[8*i +: 8];
      exp_b.push_back(b);
      c = crc_byte(c, b);
      send_byte(b);
    end
    if (v.fcs_mode != 0) begin
      fcs = ~c;
      if (v.fcs_mode == 2) fcs = fcs ^ 16'h0001;
      for (int k = 0; k < 2; k++) begin
        b = fcs[8*k +: 8];
        exp_b.push_back(b);
        c = crc_byte(c, b);
        send_byte(b);
      end
    end
    if (v.has_extra) exp_b.push_back(v.extra);
    case (v.tail)
      1: begin
        repeat (7) tick(1'b1);
        tx_ones = 0;
      end
      2: begin
        send_stuffed_bit(1'b0);
        send_stuffed_bit(1'b1);
        send_stuffed_bit(1'b0);
        send_stuffed_bit(1'b1);
        send_flag();
      end
      default: send_flag();
    endcase
    send_flag();
    send_flag();
    check({v.name, "_starts"}, 32'(n_start), 32'(v.exp_starts));
    check({v.name, "_ends"}, 32'(n_end), 32'(v.exp_ends));
    check({v.name, "_nbytes"}, 32'(n_byte), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < 16; i++)
      check($sformatf("%s_byte%0d", v.name, i), 32'(got[i]), 32'(exp_b[i]));
    if (v.exp_ends > 0)
      check({v.name, "_fcs"}, 32'(last_fcs), 32'((v.fcs_kind == 1) ? c : v.exp_fcs));
    check({v.name, "_strobe_rules"}, 32'(viol), 32'd0);
    check({v.name, "_idle_after"}, 32'(receiving), 32'd0);
  endtask

  initial begin
    logic [7:0] b81;
    valid_rst = 1'b1;
    rx        = 1'b1;
    inhibit   = 1'b0;
    recv_m    = 1'b0;
    end_prev  = 1'b0;
    tx_ones   = 0;
    clr_acc();

    //        name        n  payload             fcs tail st en fk expected   extra
    add_vec("idle",      0, 48'h0,              0, 0, 0, 0, 0, 16'h0000, 1'b0, 8'h00);
    add_vec("frame4",    4, 48'h0000_0001_00FE, 1, 0, 1, 1, 0, 16'hF0B8, 1'b0, 8'h00);
    add_vec("stuff_ff",  3, 48'h0000_0001_7EFF, 1, 0, 1, 1, 0, 16'hF0B8, 1'b0, 8'h00);
    add_vec("abort",     3, 48'h0000_00C3_0FA5, 0, 1, 1, 1, 0, 16'h0000, 1'b0, 8'h00);
    add_vec("resync",    1, 48'h0000_0000_0042, 1, 0, 1, 1, 0, 16'hF0B8, 1'b0, 8'h00);
    add_vec("misalign",  2, 48'h0000_0000_3412, 0, 2, 1, 1, 0, 16'h0000, 1'b1, 8'hEA);
    add_vec("bad_fcs",   2, 48'h0000_0000_AA55, 2, 0, 1, 1, 1, 16'h0000, 1'b0, 8'h00);

    repeat (2) @(posedge econet_clk);
    #1;
    check("reset_outputs", {rx_byte, rx_fcs, rx_byte_ready, rx_frame_start, rx_frame_end,
                            receiving, 4'h0}, 32'd0);
    valid_rst = 1'b0;

    foreach (vq[i]) run_vec(vq[i]);

    // Exact latencies: start one cycle after the 8th bit, byte one cycle later, end two after.
    clr_acc();
    send_flag();
    send_flag();
    b81 = 8'h81;
    for (int i = 0; i < 7; i++) tick(b81[i]);
    check("lat_no_early_start", 32'(n_start), 32'd0);
    tick(b81[7]);
    check("lat_start", 32'(rx_frame_start), 32'd1);
    check("lat_byte_not_yet", 32'(rx_byte_ready), 32'd0);
    tick(1'b0);
    check("lat_byte_ready", 32'(rx_byte_ready), 32'd1);
    check("lat_byte_val", 32'(rx_byte), 32'h81);
    repeat (6) tick(1'b1);
    tick(1'b0);
    check("lat_end_not_yet", 32'(rx_frame_end), 32'd0);
    tick(1'b0);
    check("lat_end", 32'(rx_frame_end), 32'd1);
    check("lat_fcs", 32'(rx_fcs), 32'(crc_byte(16'hFFFF, 8'h81)));
    for (int i = 1; i < 8; i++) tick((i == 7) ? 1'b0 : 1'b1);
    tx_ones = 0;
    send_flag();
    check("lat_strobe_rules", 32'(viol), 32'd0);

    // inhibit mid-frame aborts the frame and keeps the receiver deaf while high.
    clr_acc();
    send_flag();
    send_byte(8'h11);
    send_byte(8'h22);
    inhibit = 1'b1;
    tick(1'b0);
    tick(1'b1);
    check("inh_bytes", 32'(n_byte), 32'd2);
    check("inh_end", 32'(n_end), 32'd1);
    check("inh_fcs", 32'(last_fcs), 32'd0);
    send_flag();
    send_flag();
    send_byte(8'h44);
    check("inh_deaf", 32'(n_start), 32'd1);
    inhibit = 1'b0;
    clr_acc();
    send_flag();
    send_byte(8'h33);
    send_flag();
    send_flag();
    check("inh_resync_start", 32'(n_start), 32'd1);
    check("inh_resync_byte", 32'(got[0]), 32'h33);
    check("inh_resync_end", 32'(n_end), 32'd1);
    check("inh_strobe_rules", 32'(viol), 32'd0);

    // Reset mid-frame: outputs clear at once and no frame end follows.
    clr_acc();
    send_flag();
    send_byte(8'h3C);
    send_byte(8'hC3);
    tick(1'b0);
    check("rst_pre_receiving", 32'(receiving), 32'd1);
    #2;
    valid_rst = 1'b1;
    #1;
    check("rst_outputs", {rx_byte, rx_fcs, rx_byte_ready, rx_frame_start, rx_frame_end,
                          receiving, 4'h0}, 32'd0);
    recv_m   = 1'b0;
    end_prev = 1'b0;
    clr_acc();
    repeat (3) tick(1'b1);
    valid_rst = 1'b0;
    send_byte(8'h0F);
    send_flag();
    send_flag();
    check("rst_no_end", 32'(n_end), 32'd0);
    check("rst_no_start", 32'(n_start), 32'd0);
    run_vec(vq[1]);

    // Oversize frame: octet 2049 forces an abort and is not delivered.
    clr_acc();
    send_flag();
    repeat (2049) send_byte(8'h00);
    send_flag();
    send_flag();
    check("big_starts", 32'(n_start), 32'd1);
    check("big_bytes", 32'(n_byte), 32'd2048);
    check("big_ends", 32'(n_end), 32'd1);
    check("big_fcs", 32'(last_fcs), 32'd0);
    check("big_strobe_rules", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
